// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller and the mult/div unit.
package hazard_pkg;

  // Tuse value meaning "this operand is not read"
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew values an instruction carries into E
  localparam logic [1:0] TNEW_ZERO = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  // Default busy lengths of the mult/div unit after a start leaves E
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  // Tnew ages by one stage per cycle, never below zero
  function automatic logic [1:0] tnew_age(input logic [1:0] tnew);
    return (tnew == TNEW_ZERO) ? TNEW_ZERO : tnew - 2'd1;
  endfunction

  // A source hazards against a slot when it names the slot's destination
  // (never $0) and needs the value before the slot can produce it
  function automatic logic src_haz(input logic [4:0] src,
                                   input logic [1:0] tuse,
                                   input logic [4:0] dst,
                                   input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage view of the hazard controller: D-instruction fields in,
// stall / bubble / mult-div busy out.
interface hazard_ctrl_if;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_rs_tuse;
  logic [1:0] D_rt_tuse;
  logic [4:0] D_dst;
  logic [1:0] D_tnew;
  logic       D_md_use;
  logic       D_md_start;
  logic       D_md_div;
  logic       stall;
  logic       E_bubble;
  logic       md_busy;

  // Decode stage drives the instruction fields and obeys the stall
  modport master (
    output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_dst, D_tnew,
    output D_md_use, D_md_start, D_md_div,
    input  stall, E_bubble, md_busy
  );

  // Hazard controller consumes the fields and produces the stall
  modport slave (
    input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_dst, D_tnew,
    input  D_md_use, D_md_start, D_md_div,
    output stall, E_bubble, md_busy
  );
endinterface

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Shadow busy counter for the multi-cycle mult/div unit. Loaded when a
// start sits in E, counts down to zero in lockstep with the real unit.
module md_busy_cnt
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = hazard_pkg::MULT_CYCLES,
  parameter int DIV_CYCLES  = hazard_pkg::DIV_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  logic [CNT_W-1:0] r_md_cnt;

  // Load on a start in E, otherwise count down and rest at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md_cnt <= '0;
    end else if (i_start) begin
      r_md_cnt <= i_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - 1'b1;
    end
  end

  assign o_busy = (r_md_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble controller for the 5-stage MIPS pipeline. Tracks dst/Tnew
// of the instructions in E and M, compares against D's sources and Tuse,
// and holds mult/div users in D while HI/LO is not ready.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = hazard_pkg::MULT_CYCLES,
  parameter int DIV_CYCLES  = hazard_pkg::DIV_CYCLES
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  // E slot
  logic [4:0] r_e_dst;
  logic [1:0] r_e_tnew;
  logic       r_e_start;
  logic       r_e_div;
  // M slot
  logic [4:0] r_m_dst;
  logic [1:0] r_m_tnew;

  logic w_rs_haz;
  logic w_rt_haz;
  logic w_md_haz;
  logic w_stall;
  logic w_cnt_busy;

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_start  (r_e_start),
    .i_is_div (r_e_div),
    .o_busy   (w_cnt_busy)
  );

  // Hazard detection from current slots and D fields; Tuse=3 never hazards
  // because Tnew never exceeds 2
  always_comb begin
    w_rs_haz = src_haz(hz.D_rs, hz.D_rs_tuse, r_e_dst, r_e_tnew) |
               src_haz(hz.D_rs, hz.D_rs_tuse, r_m_dst, r_m_tnew);
    w_rt_haz = src_haz(hz.D_rt, hz.D_rt_tuse, r_e_dst, r_e_tnew) |
               src_haz(hz.D_rt, hz.D_rt_tuse, r_m_dst, r_m_tnew);
    w_md_haz = hz.D_md_use & (r_e_start | w_cnt_busy);
    w_stall  = w_rs_haz | w_rt_haz | w_md_haz;
  end

  assign hz.stall    = w_stall;
  assign hz.E_bubble = w_stall;
  assign hz.md_busy  = r_e_start | w_cnt_busy;

  // E slot takes the D instruction, or a bubble while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e_dst   <= 5'd0;
      r_e_tnew  <= TNEW_ZERO;
      r_e_start <= 1'b0;
      r_e_div   <= 1'b0;
    end else if (w_stall) begin
      r_e_dst   <= 5'd0;
      r_e_tnew  <= TNEW_ZERO;
      r_e_start <= 1'b0;
      r_e_div   <= 1'b0;
    end else begin
      r_e_dst   <= hz.D_dst;
      r_e_tnew  <= hz.D_tnew;
      r_e_start <= hz.D_md_start;
      r_e_div   <= hz.D_md_div;
    end
  end

  // M slot always advances from E, aging Tnew by one stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m_dst  <= 5'd0;
      r_m_tnew <= TNEW_ZERO;
    end else begin
      r_m_dst  <= r_e_dst;
      r_m_tnew <= tnew_age(r_e_tnew);
    end
  end

endmodule
